// File: rtl/lms_stream_sched.sv
// -----------------------------------------------------------------------------
// lms_stream_sched
//
// Paces the LMS echo canceller off two read-side FIFOs (microphone audio and
// UDP reference). After enable it waits for both FIFOs to fill to a prefill
// level, then pops one sample pair per sample_tick. A tick that finds either
// FIFO empty is an underrun: nothing is popped and the scheduler stalls until
// both FIFOs recover to a resume level.
//
// Optional feature (macro LMS_STEP_SCHED_EN):
//   defined   - step_size is STEP_COARSE during convergence and switches to
//               STEP_FINE once CONV_SAMPLES samples have been consumed.
//   undefined - step_size is the constant STEP_FINE.
//
// Ports
//   audio_clk     in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   ctrl_en       in   run request; low forces IDLE
//   sample_tick   in   one-cycle pulse per audio sample period
//   audio_empty   in   mic FIFO empty flag
//   audio_level   in   mic FIFO water level [LVL_W]
//   udp_empty     in   reference FIFO empty flag
//   udp_level     in   reference FIFO water level [LVL_W]
//   rd_en         out  shared pop strobe to both FIFOs
//   lms_en        out  LMS enable, aligned with FIFO read data
//   step_size     out  LMS step size [16]
//   state         out  IDLE=0, PREFILL=1, RUN=2, STALL=3
//   sample_cnt    out  samples popped since last enable (saturating) [24]
//   underrun      out  one-cycle underrun pulse
//   underrun_cnt  out  underrun events since reset (saturating) [16]
// -----------------------------------------------------------------------------
module lms_stream_sched #(
    parameter int          LVL_W        = 11,
    parameter int          PREFILL_LVL  = 256,
    parameter int          RESUME_LVL   = 32,
    parameter int          CONV_SAMPLES = 4096,
    parameter logic [15:0] STEP_COARSE  = 16'h001e,
    parameter logic [15:0] STEP_FINE    = 16'h000f
) (
    input  logic             audio_clk,
    input  logic             rst_n,
    input  logic             ctrl_en,
    input  logic             sample_tick,
    input  logic             audio_empty,
    input  logic [LVL_W-1:0] audio_level,
    input  logic             udp_empty,
    input  logic [LVL_W-1:0] udp_level,
    output logic             rd_en,
    output logic             lms_en,
    output logic [15:0]      step_size,
    output logic [1:0]       state,
    output logic [23:0]      sample_cnt,
    output logic             underrun,
    output logic [15:0]      underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        RUN     = 2'd2,
        STALL   = 2'd3
    } state_t;

    localparam logic [LVL_W-1:0] PREFILL_THR = LVL_W'(PREFILL_LVL);
    localparam logic [LVL_W-1:0] RESUME_THR  = LVL_W'(RESUME_LVL);
    localparam logic [23:0]      CNT_MAX     = 24'hffffff;
    localparam logic [15:0]      UCNT_MAX    = 16'hffff;

    state_t state_q;
    logic   prefill_ok;
    logic   resume_ok;
    logic   fifos_ready;

    assign state       = state_q;
    assign prefill_ok  = (audio_level >= PREFILL_THR) && (udp_level >= PREFILL_THR);
    assign resume_ok   = (audio_level >= RESUME_THR)  && (udp_level >= RESUME_THR);
    assign fifos_ready = !audio_empty && !udp_empty;

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values; later assignments in the block
    // deliberately override earlier ones (e.g. the sample_cnt clear).
    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_en        <= 1'b0;
            lms_en       <= 1'b0;
            sample_cnt   <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            // Pulses default low; the FIFO has one cycle of read latency, so
            // lms_en is simply rd_en delayed. A pop already registered when
            // ctrl_en falls still flows through to lms_en and the count.
            rd_en    <= 1'b0;
            underrun <= 1'b0;
            lms_en   <= rd_en;

            if (rd_en && (sample_cnt != CNT_MAX)) begin
                sample_cnt <= sample_cnt + 24'd1;
            end

            if (!ctrl_en) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= PREFILL;
                        sample_cnt <= '0;
                    end
                    PREFILL: begin
                        if (prefill_ok) state_q <= RUN;
                    end
                    RUN: begin
                        if (sample_tick) begin
                            if (fifos_ready) begin
                                rd_en <= 1'b1;
                            end else begin
                                underrun <= 1'b1;
                                if (underrun_cnt != UCNT_MAX) begin
                                    underrun_cnt <= underrun_cnt + 16'd1;
                                end
                                state_q <= STALL;
                            end
                        end
                    end
                    STALL: begin
                        // Ticks arriving here are dropped on purpose.
                        if (resume_ok) state_q <= RUN;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef LMS_STEP_SCHED_EN
    localparam logic [23:0] CONV_THR = 24'(CONV_SAMPLES);

    // Registered from the count, so the switch lands one cycle after the
    // threshold is reached and reverts one cycle after the count clears.
    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) begin
            step_size <= STEP_COARSE;
        end else begin
            step_size <= (sample_cnt >= CONV_THR) ? STEP_FINE : STEP_COARSE;
        end
    end
`else
    logic unused_step_cfg;

    assign step_size       = STEP_FINE;
    assign unused_step_cfg = ^{STEP_COARSE, 24'(CONV_SAMPLES)};
`endif

endmodule

// File: tb/tb_lms_stream_sched.sv
module tb_lms_stream_sched;

    localparam int          LVL_W  = 11;
    localparam int          PRE    = 256;
    localparam int          RES    = 32;
    localparam int          CONV   = 4;
    localparam logic [15:0] COARSE = 16'h001e;
    localparam logic [15:0] FINE   = 16'h000f;

    localparam int M_IDLE = 0, M_PREFILL = 1, M_RUN = 2, M_STALL = 3;

    logic             audio_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ctrl_en = 1'b0;
    logic             sample_tick = 1'b0;
    logic             audio_empty = 1'b1;
    logic [LVL_W-1:0] audio_level = '0;
    logic             udp_empty = 1'b1;
    logic [LVL_W-1:0] udp_level = '0;
    logic             rd_en;
    logic             lms_en;
    logic [15:0]      step_size;
    logic [1:0]       state;
    logic [23:0]      sample_cnt;
    logic             underrun;
    logic [15:0]      underrun_cnt;

    always #5 audio_clk = ~audio_clk;

    lms_stream_sched #(
        .LVL_W       (LVL_W),
        .PREFILL_LVL (PRE),
        .RESUME_LVL  (RES),
        .CONV_SAMPLES(CONV),
        .STEP_COARSE (COARSE),
        .STEP_FINE   (FINE)
    ) dut (
        .audio_clk   (audio_clk),
        .rst_n       (rst_n),
        .ctrl_en     (ctrl_en),
        .sample_tick (sample_tick),
        .audio_empty (audio_empty),
        .audio_level (audio_level),
        .udp_empty   (udp_empty),
        .udp_level   (udp_level),
        .rd_en       (rd_en),
        .lms_en      (lms_en),
        .step_size   (step_size),
        .state       (state),
        .sample_cnt  (sample_cnt),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model: expected outputs after each clock edge.
    int          m_state;
    bit          m_rd, m_lms, m_urun;
    int unsigned m_cnt, m_ucnt;
    logic [15:0] m_step;

    function automatic logic [15:0] step_for(input int unsigned cnt);
`ifdef LMS_STEP_SCHED_EN
        return (cnt >= CONV) ? FINE : COARSE;
`else
        return FINE;
`endif
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_rd    = 0;
        m_lms   = 0;
        m_urun  = 0;
        m_cnt   = 0;
        m_ucnt  = 0;
        m_step  = step_for(0);
    endtask

    task automatic model_edge();
        bit both_pre, both_res, ready;
        both_pre = (audio_level >= PRE) && (udp_level >= PRE);
        both_res = (audio_level >= RES) && (udp_level >= RES);
        ready    = !audio_empty && !udp_empty;
        m_step   = step_for(m_cnt);
        m_lms    = m_rd;
        if (m_rd && m_cnt != 32'h00ffffff) m_cnt++;
        m_rd   = 0;
        m_urun = 0;
        if (!ctrl_en) m_state = M_IDLE;
        else if (m_state == M_IDLE) begin
            m_state = M_PREFILL;
            m_cnt   = 0;
        end
        else if (m_state == M_PREFILL && both_pre) m_state = M_RUN;
        else if (m_state == M_STALL && both_res)   m_state = M_RUN;
        else if (m_state == M_RUN && sample_tick) begin
            if (ready) m_rd = 1;
            else begin
                m_urun = 1;
                if (m_ucnt < 65535) m_ucnt++;
                m_state = M_STALL;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".state"},        32'(state),        32'(m_state));
        check({ctx, ".rd_en"},        32'(rd_en),        32'(m_rd));
        check({ctx, ".lms_en"},       32'(lms_en),       32'(m_lms));
        check({ctx, ".underrun"},     32'(underrun),     32'(m_urun));
        check({ctx, ".underrun_cnt"}, 32'(underrun_cnt), m_ucnt);
        check({ctx, ".sample_cnt"},   32'(sample_cnt),   m_cnt);
        check({ctx, ".step_size"},    32'(step_size),    32'(m_step));
    endtask

    task automatic set_in(input bit en, input bit tick, input bit ae, input int al,
                          input bit ue, input int ul);
        ctrl_en     = en;
        sample_tick = tick;
        audio_empty = ae;
        audio_level = LVL_W'(al);
        udp_empty   = ue;
        udp_level   = LVL_W'(ul);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle(input string ctx);
        @(posedge audio_clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_all(ctx);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        cycle("reset_hold");
        rst_n = 1'b1;

        set_in(0, 0, 1, 0, 1, 0);
        cycle("idle");
        cycle("idle2");

        // Prefill ramp: hold at 255, and with only one FIFO at 256.
        set_in(1, 0, 0, 0, 0, 0);
        cycle("to_prefill");
        for (int lv = 250; lv <= 255; lv++) begin
            set_in(1, 1, 0, lv, 0, lv);
            cycle("prefill_ramp");
        end
        set_in(1, 0, 0, 256, 0, 255);
        cycle("prefill_one_side");
        set_in(1, 0, 0, 256, 0, 256);
        cycle("prefill_exit");

        // Single ticks, then back-to-back ticks; step switch after 4 pops.
        for (int k = 0; k < 5; k++) begin
            set_in(1, 1, 0, 300, 0, 300);
            cycle("tick");
            set_in(1, 0, 0, 300, 0, 300);
            repeat (3) cycle("after_tick");
        end
        set_in(1, 1, 0, 300, 0, 300);
        repeat (3) cycle("b2b_tick");
        set_in(1, 0, 0, 300, 0, 300);
        repeat (3) cycle("b2b_after");

        // Underrun on the reference FIFO, stall at 31, resume at 32.
        set_in(1, 1, 0, 100, 1, 100);
        cycle("underrun");
        set_in(1, 1, 0, 31, 0, 31);
        repeat (3) cycle("stall_31");
        set_in(1, 0, 0, 32, 0, 32);
        cycle("resume_32");
        set_in(1, 0, 0, 300, 0, 300);
        cycle("run_again");

        // ctrl_en drop coincident with a tick.
        set_in(0, 1, 0, 300, 0, 300);
        cycle("drop_on_tick");
        set_in(0, 0, 0, 300, 0, 300);
        cycle("idle_after_drop");
        set_in(1, 0, 0, 300, 0, 300);
        cycle("reenable");
        cycle("reenable_run");

        // Asynchronous reset while rd_en is high.
        set_in(1, 1, 0, 300, 0, 300);
        cycle("pre_async");
        set_in(1, 0, 0, 300, 0, 300);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        cycle("async_hold");
        rst_n = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int sel, al, ul;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       begin al = $urandom_range(0, 40);    ul = $urandom_range(0, 40);    end
                1:       begin al = $urandom_range(250, 300); ul = $urandom_range(250, 300); end
                2:       begin al = $urandom_range(28, 36);   ul = $urandom_range(28, 36);   end
                default: begin al = $urandom_range(0, 2047);  ul = $urandom_range(0, 2047);  end
            endcase
            set_in($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 3,
                   $urandom_range(0, 9) == 0, al, $urandom_range(0, 9) == 0, ul);
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lms_stream_sched.md
LMS_STREAM_SCHED -- requirements
Module: lms_stream_sched

Interface
REQ-001 SHALL provide parameter LVL_W, default 11, width of FIFO water-level inputs.
REQ-002 SHALL provide parameter PREFILL_LVL, default 256, both-FIFO level required to leave PREFILL.
REQ-003 SHALL provide parameter RESUME_LVL, default 32, both-FIFO level required to leave STALL.
REQ-004 SHALL provide parameter CONV_SAMPLES, default 4096, sample count ending the coarse-step phase.
REQ-005 SHALL provide parameter STEP_COARSE, default 16'h001e, LMS step during convergence.
REQ-006 SHALL provide parameter STEP_FINE, default 16'h000f, LMS step after convergence.
REQ-007 SHALL have port: audio_clk  in  1  clock; all logic on its rising edge.
REQ-008 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port: ctrl_en  in  1  run request; low forces IDLE.
REQ-010 SHALL have port: sample_tick  in  1  one-cycle pulse per audio sample period.
REQ-011 SHALL have ports: audio_empty  in  1 and audio_level  in  LVL_W  mic-FIFO read-side empty flag and water level.
REQ-012 SHALL have ports: udp_empty  in  1 and udp_level  in  LVL_W  reference-FIFO read-side empty flag and water level.
REQ-013 SHALL have port: rd_en  out  1  shared pop strobe to both FIFOs.
REQ-014 SHALL have port: lms_en  out  1  LMS enable, aligned to FIFO read data.
REQ-015 SHALL have port: step_size  out  16  LMS step size.
REQ-016 SHALL have ports: state  out  2  (IDLE=0, PREFILL=1, RUN=2, STALL=3); sample_cnt  out  24; underrun  out  1; underrun_cnt  out  16.

Function
REQ-017 SHALL transition IDLE->PREFILL when ctrl_en=1; clear sample_cnt on this transition.
REQ-018 SHALL transition PREFILL->RUN when audio_level>=PREFILL_LVL and udp_level>=PREFILL_LVL in the same cycle.
REQ-019 In RUN, on a cycle with sample_tick=1 and both empties low, SHALL assert registered rd_en for exactly one cycle, the cycle following.
REQ-020 In RUN, on a cycle with sample_tick=1 and either empty high, SHALL not pop, SHALL pulse underrun one cycle, increment underrun_cnt (saturating at 16'hffff), and enter STALL.
REQ-021 SHALL transition STALL->RUN when both levels >=RESUME_LVL; ticks seen in STALL are dropped without counting.
REQ-022 SHALL transition any state->IDLE on ctrl_en=0, with ctrl_en=0 taking priority over all other conditions in that cycle.
REQ-023 SHALL never assert rd_en in IDLE, PREFILL or STALL; a rd_en already registered when ctrl_en falls SHALL still complete.
REQ-024 SHALL drive lms_en as rd_en delayed one cycle (one-cycle FIFO read latency); lms_en is two cycles after the qualifying tick.
REQ-025 SHALL increment sample_cnt on each rd_en, saturating at 24'hffffff.
REQ-026 SHALL keep underrun_cnt across IDLE; it is cleared only by reset.
REQ-027 SHALL ignore sample_tick asserted on consecutive cycles beyond pop-rate: each tick cycle is evaluated independently; back-to-back pops are legal.

Reset
REQ-028 On rst_n=0 SHALL set state=IDLE, rd_en=0, lms_en=0, sample_cnt=0, underrun=0, underrun_cnt=0, and step_size per REQ-029/REQ-030, asynchronously; release is synchronous to audio_clk.

Configuration
REQ-029 With LMS_STEP_SCHED_EN defined, step_size SHALL be STEP_COARSE while sample_cnt<CONV_SAMPLES and registered STEP_FINE from the cycle after sample_cnt reaches CONV_SAMPLES; it SHALL return to STEP_COARSE when sample_cnt clears.
REQ-030 Without LMS_STEP_SCHED_EN, step_size SHALL be constant STEP_FINE, including in reset.

Verification
REQ-031 ctrl_en=1, levels ramp to 255/256 -> state stays PREFILL at 255, RUN one cycle after both reach 256.
REQ-032 RUN, tick at cycle N, both non-empty -> rd_en=1 at N+1 only, lms_en=1 at N+2 only, sample_cnt +1.
REQ-033 RUN, tick with udp_empty=1 -> no rd_en, underrun pulse, underrun_cnt 0->1, state=STALL; levels 31 stays STALL, 32 -> RUN.
REQ-034 Macro defined, CONV_SAMPLES=4 -> step_size 16'h001e for pops 1-3, 16'h000f after 4th pop; macro undefined -> 16'h000f always.
REQ-035 ctrl_en dropped same cycle as tick in RUN -> state=IDLE, no new rd_en; re-enable clears sample_cnt, underrun_cnt retained.
REQ-036 rst_n asserted mid-RUN with rd_en high -> all outputs to reset values immediately without a clock edge.
